icache_axi_refill: RTL and testbench
====================================

// Module: icache_axi_refill
// PURPOSE
//  Refill engine between the IF-stage icache and the AXI read port. Accepts a line-miss request
//  (icache_rd_req/icache_addr) and issues one 16-beat INCR AXI read burst. Collects the beats into
//  a line buffer and returns the line as icache_data[0:15] with a one-cycle icache_gnt pulse.
//  Read-only: no AW/W/B channels.
// PARAMETERS
//  LINE_WORDS   16    words per cache line; arlen = LINE_WORDS-1
//  OFFSET_W     6     byte-offset bits forced to zero on araddr
//  AXI_ID       4'd0  constant arid; rid is not checked
// PORTS
//  clk            in   1      system clock
//  rst            in   1      reset: synchronous, active-high; single clock domain
//  icache_rd_req  in   1      line refill request, held by icache until gnt
//  icache_addr    in   32     line address; low OFFSET_W bits ignored
//  icache_gnt     out  1      one-cycle pulse: line buffer complete and valid
//  icache_data    out  32x16  line buffer, unpacked [0:LINE_WORDS-1]; word i = address base+4*i
//  arid           out  4      AXI_ID
//  araddr         out  32     {addr[31:OFFSET_W], OFFSET_W'b0}
//  arlen          out  8      LINE_WORDS-1 (8'd15)
//  arsize         out  3      3'b010 (4 bytes)
//  arburst        out  2      2'b01 (INCR)
//  arvalid        out  1      AR request valid
//  arready        in   1      AR accepted
//  rdata          in   32     read beat data
//  rresp          in   2      read response
//  rlast          in   1      last beat flag
//  rvalid         in   1      beat valid
//  rready         out  1      beat accept
//  refill_err     out  1      sticky: rresp!=OKAY, or rlast inconsistent with beat count
// BEHAVIOUR
//  Reset:
//   - state=IDLE; arvalid=0, rready=0, icache_gnt=0, refill_err=0.
//   - beat_cnt=0; icache_data all zero; latched address=0.
//  FSM states: IDLE -> AR -> R -> DONE -> IDLE.
//  IDLE:
//   - If icache_rd_req=1, latch {icache_addr[31:6],6'b0} into line_addr and go to AR next cycle.
//   - arvalid is registered: it is never asserted in the same cycle as the request.
//  AR:
//   - arvalid=1, araddr=line_addr. AR payload is stable until handshake.
//   - On arvalid&&arready: go to R, beat_cnt=0.
//  R:
//   - rready=1. On each rvalid&&rready: icache_data[beat_cnt]<=rdata, beat_cnt++.
//   - At the handshake with beat_cnt==LINE_WORDS-1: go to DONE. rlast is not used for completion.
//   - rlast=1 at any other beat, or rlast=0 at the final beat: set refill_err; counting continues.
//   - rresp!=2'b00 on any beat: set refill_err; the data is still stored.
//  DONE (1 cycle):
//   - icache_gnt=1 iff icache_rd_req=1 in this cycle; next state IDLE.
//   - If the requester has dropped icache_rd_req, no gnt is issued; the buffer is still kept.
//  Data hold: icache_data stays unchanged from DONE until the first R beat of the next burst.
//   The icache writes its RAMs the cycle after gnt, so this hold is mandatory.
//  Back-to-back requests:
//   - icache_rd_req is sampled only in IDLE.
//   - A request still high in the cycle after DONE starts a new refill; that is legal but wasteful.
//  Minimum latency, request to gnt: 1 (IDLE) + 1 (AR) + 16 (beats) + 1 (DONE) = 19 cycles at
//   zero-wait AXI.
//  Stalls: arready=0 or rvalid=0 stall indefinitely. No timeout.
//  Reset mid-burst:
//   - Immediate return to IDLE with all outputs at reset values.
//   - The AXI slave shares rst, so the outstanding burst is abandoned.
//  beat_cnt is $clog2(LINE_WORDS) bits wide and wraps to 0 on the final beat.
//  refill_err clears only on rst.
// STRUCTURE
//  Package icache_pkg:
//   - refill_state_t enum {IDLE, AR, R, DONE}.
//   - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00.
//   - LINE_WORDS and OFFSET_W constants, shared with icache.
//  Single module; no sub-module. The line buffer is a plain register array written by beat index.
// TESTING
//  1. Zero-wait slave: icache_rd_req=1, addr=32'hBFC0_0044.
//     -> araddr=32'hBFC0_0040, arlen=15, arburst=01, arsize=010.
//     -> rdata=32'h1000+i gives icache_data[i]=32'h1000+i.
//     -> gnt a single pulse 19 cycles after the request.
//  2. Random arready/rvalid stalls (0-5 cycles):
//     -> beats stored in order.
//     -> exactly 16 handshakes; one gnt.
//     -> icache_data stable for 3 cycles after gnt.
//  3. rresp=2'b10 on beat 7 -> refill_err=1 stays high; data still stored; gnt still issued.
//     Also: rlast asserted on beat 5 -> refill_err=1.
//  4. rst=1 while in R after beat 8:
//     -> next cycle IDLE; rready=0, gnt=0.
//     -> next request after reset gives a clean 16-beat refill.
//  5. icache_rd_req deasserted during R -> no gnt in DONE; block returns to IDLE.
//     A subsequent request at a new address refills correctly.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared icache refill types and AXI encodings
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } refill_state_t;

    localparam int LINE_WORDS = 16;
    localparam int OFFSET_W   = 6;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/icache_axi_refill.sv
// rtl/icache_axi_refill.sv - icache line refill over a single AXI INCR read burst
module icache_axi_refill #(
    parameter int         LINE_WORDS = icache_pkg::LINE_WORDS,
    parameter int         OFFSET_W   = icache_pkg::OFFSET_W,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_rd_req,
    input  logic [31:0] icache_addr,
    output logic        icache_gnt,
    output logic [31:0] icache_data [0:LINE_WORDS-1],
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        refill_err
);
    import icache_pkg::*;

    localparam int CNT_W = $clog2(LINE_WORDS);

    refill_state_t    state;
    refill_state_t    state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [31:0]      line_addr;
    logic             beat_hs;
    logic             last_beat;
    logic             unused_addr_bits;

    assign unused_addr_bits = &{1'b0, icache_addr[OFFSET_W-1:0]};

    assign beat_hs   = (state == R) && rvalid;
    assign last_beat = (beat_cnt == CNT_W'(LINE_WORDS - 1));

    assign arid    = AXI_ID;
    assign araddr  = line_addr;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        icache_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (icache_rd_req) begin
                    state_next = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = R;
                end
            end
            R: begin
                rready = 1'b1;
                // Completion is by beat count only; rlast merely cross-checks it.
                if (rvalid && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                icache_gnt = icache_rd_req;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line buffer is only written by R beats, so it holds through DONE and beyond.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            line_addr  <= '0;
            refill_err <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                icache_data[i] <= '0;
            end
        end else begin
            if (state == IDLE && icache_rd_req) begin
                line_addr <= {icache_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            if (state == AR && arready) begin
                beat_cnt <= '0;
            end
            if (beat_hs) begin
                icache_data[beat_cnt] <= rdata;
                beat_cnt              <= beat_cnt + 1'b1;
                if (rresp != AXI_RESP_OKAY || rlast != last_beat) begin
                    refill_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// tb/tb_icache_axi_refill.sv - directed and randomized refill checks against a line model
module tb_icache_axi_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_rd_req;
    logic [31:0] icache_addr;
    logic        icache_gnt;
    logic [31:0] icache_data [0:15];
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        refill_err;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] exp_line [16];
    bit          exp_err;
    int          gnt_count;
    int          gnt_cycle;
    int          beats;

    always #5 clk = ~clk;

    icache_axi_refill dut (
        .clk          (clk),
        .rst          (rst),
        .icache_rd_req(icache_rd_req),
        .icache_addr  (icache_addr),
        .icache_gnt   (icache_gnt),
        .icache_data  (icache_data),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .refill_err   (refill_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s[%0d]", tag, i), icache_data[i], exp_line[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        icache_rd_req = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    // One request from the icache side plus a behavioural AXI slave. Negative
    // beat indices disable the corresponding fault / event.
    task automatic refill(input logic [31:0] addr, input bit stall, input bit seq_data,
                          input int bad_resp, input int bad_last, input int drop_at,
                          input int rst_at);
        bit ar_ok = 0;
        bit ar_seen = 0;
        bit fin = 0;
        bit rst_hit = 0;
        int done_k = -1;
        int k;
        beats = 0;
        gnt_count = 0;
        gnt_cycle = -1;
        for (int i = 0; i < 16; i++) begin
            exp_line[i] = seq_data ? 32'h1000 + i : $urandom();
        end
        @(negedge clk);
        icache_rd_req = 1'b1;
        icache_addr = addr;
        for (k = 0; k < 600 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            arready = !stall || ($urandom_range(0, 2) == 0);
            rvalid = ar_ok && beats < 16 && (!stall || ($urandom_range(0, 2) == 0));
            rdata = rvalid ? exp_line[beats] : $urandom();
            rresp = (beats == bad_resp) ? 2'b10 : 2'b00;
            rlast = (beats == bad_last) || (beats == 15);
            if (beats == drop_at) icache_rd_req = 1'b0;
            if (rst_at >= 0 && beats == rst_at) begin
                rst = 1'b1;
                rvalid = 1'b0;
                arready = 1'b0;
                rst_hit = 1;
            end
            #1;
            if (k == 0) chk("arvalid_not_same_cycle", arvalid, 0);
            if (icache_gnt) begin
                gnt_count++;
                if (gnt_cycle < 0) gnt_cycle = k;
            end
            if (arvalid && !ar_seen) begin
                ar_seen = 1;
                chk("araddr", araddr, addr & ~32'h3F);
                chk("arlen", arlen, 15);
                chk("arsize", arsize, 3'b010);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, 0);
            end
            if (rvalid && rready) begin
                if (rresp != 2'b00 || rlast != (beats == 15)) exp_err = 1'b1;
                beats++;
            end
            if (arvalid && arready) ar_ok = 1;
            if (rst_hit) begin
                fin = 1;
            end else if (beats == 16 && done_k < 0) begin
                done_k = k;
            end else if (done_k >= 0 && k == done_k + 1) begin
                chk("rready_low_in_done", rready, 0);
                fin = 1;
            end
        end
        if (!fin) chk("refill_timeout", 1, 0);
        @(negedge clk);
        icache_rd_req = 1'b0;
        rst = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        if (rst_hit) exp_err = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        icache_rd_req = 1'b0;
        icache_addr = '0;
        arready = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        rlast = 1'b0;
        rvalid = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_gnt", icache_gnt, 0);
        chk("rst_err", refill_err, 0);
        chk("rst_data5", icache_data[5], 0);
        rst = 1'b0;

        // Zero-wait slave, sequential data, exact latency
        refill(32'hBFC0_0044, 0, 1, -1, -1, -1, -1);
        chk("t1_beats", beats, 16);
        chk("t1_gnt_count", gnt_count, 1);
        chk("t1_gnt_cycle", gnt_cycle, 18);
        chk("t1_err", refill_err, 0);
        check_line("t1_data");

        // Random stalls, random data, buffer held after gnt
        for (int n = 0; n < 3; n++) begin
            refill($urandom(), 1, 0, -1, -1, -1, -1);
            chk("t2_beats", beats, 16);
            chk("t2_gnt_count", gnt_count, 1);
            chk("t2_err", refill_err, 0);
            check_line("t2_data");
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                check_line("t2_hold");
                chk("t2_no_arvalid", arvalid, 0);
            end
        end

        // Error response on beat 7
        refill(32'h0000_1234, 0, 0, 7, -1, -1, -1);
        chk("t3_gnt_count", gnt_count, 1);
        chk("t3_err", refill_err, exp_err);
        check_line("t3_data");
        repeat (2) @(negedge clk);
        #1;
        chk("t3_err_sticky", refill_err, 1);

        // Early rlast on beat 5
        do_reset();
        #1;
        chk("t3b_err_cleared", refill_err, 0);
        refill(32'h8000_0FC0, 1, 0, -1, 5, -1, -1);
        chk("t3b_err", refill_err, exp_err);
        chk("t3b_gnt_count", gnt_count, 1);
        check_line("t3b_data");

        // Reset after beat 8 abandons the burst
        do_reset();
        refill(32'h4000_0100, 0, 0, -1, -1, -1, 9);
        chk("t4_rready", rready, 0);
        chk("t4_gnt", icache_gnt, 0);
        chk("t4_arvalid", arvalid, 0);
        chk("t4_err", refill_err, 0);
        chk("t4_data0", icache_data[0], 0);
        refill(32'h4000_0180, 0, 0, -1, -1, -1, -1);
        chk("t4b_gnt_cycle", gnt_cycle, 18);
        chk("t4b_err", refill_err, 0);
        check_line("t4b_data");

        // Requester drops during R: no gnt, data still collected
        refill(32'h2000_0200, 0, 0, -1, -1, 10, -1);
        chk("t5_gnt_count", gnt_count, 0);
        chk("t5_beats", beats, 16);
        check_line("t5_data");
        refill(32'h2000_0A7C, 0, 1, -1, -1, -1, -1);
        chk("t5b_gnt_count", gnt_count, 1);
        chk("t5b_gnt_cycle", gnt_cycle, 18);
        check_line("t5b_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
